// File: rtl/hash_result_scan_if.sv
// Single-port memory bus shared between the result scanner (master) and the result RAM (slave).
interface hash_result_scan_if;
   logic        mem_clk;
   logic        mem_we;
   logic [15:0] mem_addr;
   logic [31:0] mem_write_data;
   logic [31:0] mem_read_data;

   modport master (
      output mem_clk,
      output mem_we,
      output mem_addr,
      output mem_write_data,
      input  mem_read_data
   );

   modport slave (
      input  mem_clk,
      input  mem_we,
      input  mem_addr,
      input  mem_write_data,
      output mem_read_data
   );
endinterface

// File: rtl/hash_result_scan.sv
// Scans NUM_NONCES H0 words for the minimum, compares it to target and writes a summary record.
// Define HASH_SCAN_COUNT_EN to add the hit_count output and a third record word.
module hash_result_scan #(
   parameter int NUM_NONCES = 16,
   parameter int IDX_W      = $clog2(NUM_NONCES)
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  start,
   input  logic [15:0]           result_addr,
   input  logic [15:0]           summary_addr,
   input  logic [31:0]           target,
   output logic                  done,
   output logic                  found,
   output logic [IDX_W-1:0]      best_nonce,
   output logic [31:0]           best_hash,
`ifdef HASH_SCAN_COUNT_EN
   output logic [IDX_W:0]        hit_count,
`endif
   hash_result_scan_if.master    mem
);

   typedef enum logic [2:0] {
      IDLE,
      PRIME,
      SCAN,
      WR_FLAG,
      WR_HASH,
      WR_COUNT,
      FIN
   } state_t;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NONCES - 1);

   function automatic logic [15:0] idx_to_16(input logic [IDX_W-1:0] idx);
      return 16'(idx);
   endfunction

   function automatic logic [31:0] flag_word(input logic hit, input logic [IDX_W-1:0] idx);
      return {hit, 15'b0, idx_to_16(idx)};
   endfunction

   state_t            state_q, state_d;
   logic              done_q, done_d;
   logic              found_q, found_d;
   logic [IDX_W-1:0]  best_nonce_q, best_nonce_d;
   logic [31:0]       best_hash_q, best_hash_d;
   logic              we_q, we_d;
   logic [15:0]       addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;

   // Working scan registers; always re-initialised by an accepted start.
   logic [31:0]       min_q, min_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [IDX_W-1:0]  rc_q, rc_d;

   logic [31:0]       word;
   logic              take;
   logic [31:0]       min_nx;
   logic [IDX_W-1:0]  idx_nx;
   logic              hit_nx;

`ifdef HASH_SCAN_COUNT_EN
   logic [IDX_W:0]    cnt_q, cnt_d;
   logic [IDX_W:0]    cnt_nx;
   logic [IDX_W:0]    hit_count_q, hit_count_d;
`endif

   assign word   = mem.mem_read_data;
   assign take   = word < min_q;
   assign min_nx = take ? word : min_q;
   assign idx_nx = take ? rc_q : idx_q;
   assign hit_nx = min_nx < target;
`ifdef HASH_SCAN_COUNT_EN
   assign cnt_nx = cnt_q + {{IDX_W{1'b0}}, (word < target)};
`endif

   always_comb begin
      state_d      = state_q;
      done_d       = 1'b0;
      found_d      = found_q;
      best_nonce_d = best_nonce_q;
      best_hash_d  = best_hash_q;
      we_d         = we_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      min_d        = min_q;
      idx_d        = idx_q;
      rc_d         = rc_q;
`ifdef HASH_SCAN_COUNT_EN
      cnt_d        = cnt_q;
      hit_count_d  = hit_count_q;
`endif
      case (state_q)
         IDLE: begin
            if (start) begin
               we_d    = 1'b0;
               addr_d  = result_addr;
               rc_d    = '0;
               min_d   = 32'hFFFF_FFFF;
               idx_d   = '0;
`ifdef HASH_SCAN_COUNT_EN
               cnt_d       = '0;
               hit_count_d = '0;
`endif
               state_d = PRIME;
            end
         end
         PRIME: begin
            addr_d  = addr_q + 16'd1;
            state_d = SCAN;
         end
         SCAN: begin
            min_d  = min_nx;
            idx_d  = idx_nx;
            rc_d   = rc_q + 1'b1;
            addr_d = addr_q + 16'd1;
`ifdef HASH_SCAN_COUNT_EN
            cnt_d  = cnt_nx;
`endif
            // Final word: results include this word and the flag write is launched.
            if (rc_q == LAST_IDX) begin
               best_hash_d  = min_nx;
               best_nonce_d = idx_nx;
               found_d      = hit_nx;
               we_d         = 1'b1;
               addr_d       = summary_addr;
               wdata_d      = flag_word(hit_nx, idx_nx);
`ifdef HASH_SCAN_COUNT_EN
               hit_count_d  = cnt_nx;
`endif
               state_d      = WR_FLAG;
            end
         end
         WR_FLAG: begin
            addr_d  = summary_addr + 16'd1;
            wdata_d = best_hash_q;
            state_d = WR_HASH;
         end
         WR_HASH: begin
`ifdef HASH_SCAN_COUNT_EN
            addr_d  = summary_addr + 16'd2;
            wdata_d = 32'(hit_count_q);
            state_d = WR_COUNT;
`else
            we_d    = 1'b0;
            done_d  = 1'b1;
            state_d = FIN;
`endif
         end
`ifdef HASH_SCAN_COUNT_EN
         WR_COUNT: begin
            we_d    = 1'b0;
            done_d  = 1'b1;
            state_d = FIN;
         end
`endif
         FIN: begin
            state_d = IDLE;
         end
         default: begin
            we_d    = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         done_q       <= 1'b0;
         found_q      <= 1'b0;
         best_nonce_q <= '0;
         best_hash_q  <= '0;
         we_q         <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
`ifdef HASH_SCAN_COUNT_EN
         hit_count_q  <= '0;
`endif
      end else begin
         state_q      <= state_d;
         done_q       <= done_d;
         found_q      <= found_d;
         best_nonce_q <= best_nonce_d;
         best_hash_q  <= best_hash_d;
         we_q         <= we_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
`ifdef HASH_SCAN_COUNT_EN
         hit_count_q  <= hit_count_d;
`endif
      end
   end

   always_ff @(posedge clk) begin
      min_q <= min_d;
      idx_q <= idx_d;
      rc_q  <= rc_d;
`ifdef HASH_SCAN_COUNT_EN
      cnt_q <= cnt_d;
`endif
   end

   assign done               = done_q;
   assign found              = found_q;
   assign best_nonce         = best_nonce_q;
   assign best_hash          = best_hash_q;
`ifdef HASH_SCAN_COUNT_EN
   assign hit_count          = hit_count_q;
`endif
   assign mem.mem_clk        = clk;
   assign mem.mem_we         = we_q;
   assign mem.mem_addr       = addr_q;
   assign mem.mem_write_data = wdata_q;

endmodule

// File: tb/tb_hash_result_scan.sv
// Scoreboard bench for hash_result_scan: driver pushes model results, a done-triggered monitor checks them.
`timescale 1ns/1ps
module tb_hash_result_scan;
   localparam int N  = 16;
   localparam int IW = $clog2(N);
`ifdef HASH_SCAN_COUNT_EN
   localparam int LAT = N + 4;
`else
   localparam int LAT = N + 3;
`endif

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          start = 1'b0;
   logic [15:0]   result_addr = '0;
   logic [15:0]   summary_addr = '0;
   logic [31:0]   target = '0;
   logic          done;
   logic          found;
   logic [IW-1:0] best_nonce;
   logic [31:0]   best_hash;
`ifdef HASH_SCAN_COUNT_EN
   logic [IW:0]   hit_count;
`endif

   hash_result_scan_if bus();

   hash_result_scan #(.NUM_NONCES(N)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .start        (start),
      .result_addr  (result_addr),
      .summary_addr (summary_addr),
      .target       (target),
      .done         (done),
      .found        (found),
      .best_nonce   (best_nonce),
      .best_hash    (best_hash),
`ifdef HASH_SCAN_COUNT_EN
      .hit_count    (hit_count),
`endif
      .mem          (bus.master)
   );

   always #5 clk = ~clk;

   // Memory model with one-cycle synchronous read and a backdoor load port.
   logic [31:0] mem [0:65535];
   logic [31:0] rd_q = '0;
   logic        bd_we = 1'b0;
   logic [15:0] bd_addr = '0;
   logic [31:0] bd_data = '0;
   always @(posedge clk) begin
      if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_write_data;
      else if (bd_we) mem[bd_addr] <= bd_data;
      rd_q <= mem[bus.mem_addr];
   end
   assign bus.mem_read_data = rd_q;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int            s_cyc;
      logic [IW-1:0] nonce;
      logic [31:0]   hash;
      logic          fnd;
      logic [15:0]   sa;
      logic [IW:0]   hits;
   } exp_t;

   exp_t sbq[$];
   int   checks = 0;
   int   passes = 0;
   int   done_seen = 0;
   logic [31:0] words [N];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
   endtask

   always @(negedge clk) begin : monitor
      exp_t        e;
      logic [15:0] a;
      if (done === 1'b1) begin
         done_seen++;
         if (sbq.size() == 0) begin
            checks++;
            $display("FAIL unexpected_done: got done=1 expected no pending scan (t=%0t)", $time);
         end else begin
            e = sbq.pop_front();
            chk("done_latency", 32'(cyc - e.s_cyc), 32'(LAT));
            chk("best_nonce", 32'(best_nonce), 32'(e.nonce));
            chk("best_hash", best_hash, e.hash);
            chk("found", 32'(found), 32'(e.fnd));
            chk("rec_flag", mem[e.sa], {e.fnd, 15'b0, 16'(e.nonce)});
            a = e.sa + 16'd1;
            chk("rec_hash", mem[a], e.hash);
`ifdef HASH_SCAN_COUNT_EN
            chk("hit_count", 32'(hit_count), 32'(e.hits));
            a = e.sa + 16'd2;
            chk("rec_count", mem[a], 32'(e.hits));
`endif
         end
      end
   end

   // Reference: minimum value, first index holding it, count below target.
   task automatic run_scan(input logic [31:0] tgt, input logic [15:0] ra, input logic [15:0] sa,
                           input bit poke_start);
      exp_t        e;
      logic [31:0] minv;
      int          first;
      int          hits;
      int          d0;
      bit          got;
      minv = words[0];
      foreach (words[i]) if (words[i] < minv) minv = words[i];
      first = -1;
      foreach (words[i]) if (first < 0 && words[i] == minv) first = i;
      hits = 0;
      foreach (words[i]) if (words[i] < tgt) hits++;
      for (int i = 0; i < N; i++) begin
         @(negedge clk);
         bd_we   = 1'b1;
         bd_addr = ra + 16'(i);
         bd_data = words[i];
      end
      @(negedge clk);
      bd_we        = 1'b0;
      result_addr  = ra;
      summary_addr = sa;
      target       = tgt;
      start        = 1'b1;
      e.s_cyc = cyc + 1;
      e.nonce = IW'(first);
      e.hash  = minv;
      e.fnd   = (minv < tgt);
      e.sa    = sa;
      e.hits  = (IW+1)'(hits);
      sbq.push_back(e);
      d0 = done_seen;
      @(negedge clk);
      start = 1'b0;
      if (poke_start) begin
         repeat (5) @(negedge clk);
         start = 1'b1;
         @(negedge clk);
         start = 1'b0;
      end
      got = 1'b0;
      for (int k = 0; k < 60 && !got; k++) begin
         @(negedge clk);
         if (done_seen != d0) got = 1'b1;
      end
      if (!got) begin
         checks++;
         $display("FAIL done_timeout: got no done expected done within 60 cycles (t=%0t)", $time);
         sbq.delete();
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic check_zero_outputs(input string tag);
      chk({tag, "_mem_we"}, 32'(bus.mem_we), 32'd0);
      chk({tag, "_mem_addr"}, 32'(bus.mem_addr), 32'd0);
      chk({tag, "_mem_wdata"}, bus.mem_write_data, 32'd0);
      chk({tag, "_done"}, 32'(done), 32'd0);
      chk({tag, "_found"}, 32'(found), 32'd0);
      chk({tag, "_best_nonce"}, 32'(best_nonce), 32'd0);
      chk({tag, "_best_hash"}, best_hash, 32'd0);
   endtask

   initial begin
      #2;
      check_zero_outputs("reset");
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);

      // Case 1: ascending words with a single small value at index 5.
      foreach (words[i]) words[i] = 32'h100 + 32'(16 * i);
      words[5] = 32'h10;
      run_scan(32'h20, 16'h0100, 16'h0200, 1'b0);
`ifdef HASH_SCAN_COUNT_EN
      run_scan(32'h101, 16'h0100, 16'h0200, 1'b0);
`endif

      // Case 2: all equal words, target below them.
      foreach (words[i]) words[i] = 32'hDEADBEEF;
      run_scan(32'h1000, 16'h0300, 16'h0400, 1'b0);

      // Case 3: tie at 7 and 12, then a minimum only in the last word.
      foreach (words[i]) words[i] = 32'h1000 + $urandom_range(0, 32'hFFFF);
      words[7] = 32'h3;
      words[12] = 32'h3;
      run_scan(32'h4, 16'h0500, 16'h0600, 1'b0);
      foreach (words[i]) words[i] = 32'h1000 + $urandom_range(0, 32'hFFFF);
      words[15] = 32'h3;
      run_scan(32'h3, 16'h0500, 16'h0600, 1'b0);

      // Case 4: zero word at index 0 with targets 0 and 1.
      foreach (words[i]) words[i] = 32'h1 + $urandom_range(0, 32'hFFFF);
      words[0] = 32'h0;
      run_scan(32'h0, 16'h0700, 16'h0800, 1'b0);
      run_scan(32'h1, 16'h0700, 16'h0800, 1'b0);

      // Saturated target, all-ones words, summary wrap and overlapping regions.
      foreach (words[i]) words[i] = 32'hFFFFFFFF;
      run_scan(32'hFFFFFFFF, 16'hFFF8, 16'hFFFF, 1'b0);
      words[9] = 32'hFFFFFFFE;
      run_scan(32'hFFFFFFFF, 16'h1000, 16'h1004, 1'b0);

      // Start pulsed during the scan must be ignored.
      foreach (words[i]) words[i] = $urandom;
      run_scan($urandom, 16'h2000, 16'h3000, 1'b1);

      // Reset while word 8 is being scanned.
      foreach (words[i]) words[i] = $urandom;
      for (int i = 0; i < N; i++) begin
         @(negedge clk);
         bd_we   = 1'b1;
         bd_addr = 16'h4000 + 16'(i);
         bd_data = words[i];
      end
      @(negedge clk);
      bd_we        = 1'b0;
      result_addr  = 16'h4000;
      summary_addr = 16'h5000;
      target       = 32'hFFFFFFFF;
      start        = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (8) @(negedge clk);
      reset_n = 1'b0;
      #1;
      check_zero_outputs("midreset");
      @(negedge clk);
      reset_n = 1'b1;
      repeat (30) @(negedge clk);
      run_scan(32'h8000_0000, 16'h4000, 16'h5000, 1'b0);

      // Randomised scans, some with heavy value collisions.
      for (int t = 0; t < 20; t++) begin
         if (t % 3 == 0) foreach (words[i]) words[i] = $urandom_range(0, 7);
         else foreach (words[i]) words[i] = $urandom;
         case (t % 4)
            0: target = 32'h0;
            1: target = 32'hFFFFFFFF;
            2: target = $urandom_range(0, 8);
            default: target = $urandom;
         endcase
         run_scan(target, 16'($urandom), 16'($urandom), 1'b0);
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
